// File: rtl/uart_rx_frame.sv
// Same-clock UART frame receiver: start, DATA_WIDTH bits MSB first, GUARD_BITS ignored, stop.
// Optional build macro RX_SYNC_EN inserts a 2-flop input synchroniser (reset to 1) ahead of the FSM.
module uart_rx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int GUARD_BITS = 1
) (
  input  logic                  clk,
  input  logic                  Rst_rx_n,
  input  logic                  Rs232_rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  input  logic                  ready,
  output logic                  done,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  clr_err
);

  localparam int MAX_BITS = (DATA_WIDTH > GUARD_BITS) ? DATA_WIDTH : GUARD_BITS;
  localparam int CW = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_BITS > 0) ? (GUARD_BITS - 1) : 0);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    DATA      = 3'd2,
    GUARD     = 3'd3,
    STOP      = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;
  logic [CW-1:0]         cnt_r;
  logic [CW-1:0]         cnt_nx_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH:0]   shift_cat_s;
  logic                  rx_s;
  logic                  shift_en_s;
  logic                  good_s;
  logic                  bad_s;
  logic                  load_s;
  logic                  ovr_set_s;

`ifdef RX_SYNC_EN
  logic [1:0] sync_r;

  // Two-flop synchroniser; resets to the idle line level so no false start appears.
  always_ff @(posedge clk or negedge Rst_rx_n) begin
    if (!Rst_rx_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], Rs232_rx};
    end
  end

  assign rx_s = sync_r[1];
`else
  assign rx_s = Rs232_rx;
`endif

  assign shift_cat_s = {shift_r, rx_s};

  // State and bit counter registers.
  always_ff @(posedge clk or negedge Rst_rx_n) begin
    if (!Rst_rx_n) begin
      state_r <= WAIT_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state decode; the counter only survives while the state is unchanged.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = {CW{1'b0}};
    shift_en_s = 1'b0;
    good_s     = 1'b0;
    bad_s      = 1'b0;
    case (state_r)
      WAIT_IDLE: begin
        if (rx_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT_IDLE;
        end
      end
      IDLE: begin
        if (!rx_s) begin
          state_nx_s = DATA;
        end else begin
          state_nx_s = IDLE;
        end
      end
      DATA: begin
        shift_en_s = 1'b1;
        if (cnt_r == DATA_LAST) begin
          if (GUARD_BITS == 0) begin
            state_nx_s = STOP;
          end else begin
            state_nx_s = GUARD;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      GUARD: begin
        if (cnt_r == GUARD_LAST) begin
          state_nx_s = STOP;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (rx_s) begin
          good_s     = 1'b1;
          state_nx_s = IDLE;
        end else begin
          bad_s      = 1'b1;
          state_nx_s = WAIT_IDLE;
        end
      end
      default: begin
        state_nx_s = WAIT_IDLE;
      end
    endcase
  end

  // A consumer hand-off on the same edge frees the holding register for the new word.
  assign load_s    = good_s && (!valid || ready);
  assign ovr_set_s = good_s && valid && !ready;

  // Data shift register, first received bit ends in the MSB.
  always_ff @(posedge clk or negedge Rst_rx_n) begin
    if (!Rst_rx_n) begin
      shift_r <= {DATA_WIDTH{1'b0}};
    end else if (shift_en_s) begin
      shift_r <= shift_cat_s[DATA_WIDTH-1:0];
    end else begin
      shift_r <= shift_r;
    end
  end

  // Holding register, status pulses and sticky overrun.
  always_ff @(posedge clk or negedge Rst_rx_n) begin
    if (!Rst_rx_n) begin
      data_out  <= {DATA_WIDTH{1'b0}};
      valid     <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done      <= good_s;
      frame_err <= bad_s;
      if (load_s) begin
        data_out <= shift_r;
        valid    <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end else begin
        valid <= valid;
      end
      if (ovr_set_s) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame (default build): frame-parsing reference model plus directed literals.
module tb_uart_rx_frame;

  localparam int DW   = 8;
  localparam int GB   = 1;
  localparam int HIST = 16384;

  logic          clk       = 1'b0;
  logic          Rst_rx_n  = 1'b0;
  logic          Rs232_rx  = 1'b1;
  logic          ready     = 1'b0;
  logic          clr_err   = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          done;
  logic          frame_err;
  logic          overrun;

  uart_rx_frame #(.DATA_WIDTH(DW), .GUARD_BITS(GB)) dut (
    .clk       (clk),
    .Rst_rx_n  (Rst_rx_n),
    .Rs232_rx  (Rs232_rx),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .done      (done),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_total  = 0;
  int edge_n   = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  logic pre_valid = 1'b0;

  // Reference model: line history plus frame positions derived from the start edge.
  logic          line_hist [0:HIST-1];
  logic          m_in_frame = 1'b0;
  logic          m_armed    = 1'b0;
  int            m_start    = 0;
  logic [DW-1:0] m_data     = '0;
  logic          m_valid    = 1'b0;
  logic          m_done     = 1'b0;
  logic          m_ferr     = 1'b0;
  logic          m_ovr      = 1'b0;

  task automatic model_step();
    logic          good;
    logic          bad;
    logic          ovr_set;
    logic [DW-1:0] word;
    if (!Rst_rx_n) begin
      m_in_frame = 1'b0;
      m_armed    = 1'b0;
      m_data     = '0;
      m_valid    = 1'b0;
      m_done     = 1'b0;
      m_ferr     = 1'b0;
      m_ovr      = 1'b0;
    end else begin
      line_hist[edge_n % HIST] = Rs232_rx;
      good = 1'b0;
      bad  = 1'b0;
      word = '0;
      if (m_in_frame) begin
        if (edge_n == m_start + DW + GB + 1) begin
          m_in_frame = 1'b0;
          for (int i = 0; i < DW; i++) word[DW-1-i] = line_hist[(m_start + 1 + i) % HIST];
          if (Rs232_rx === 1'b1) begin
            good = 1'b1;
          end else begin
            bad     = 1'b1;
            m_armed = 1'b0;
          end
        end
      end else if (m_armed) begin
        if (Rs232_rx == 1'b0) begin
          m_in_frame = 1'b1;
          m_start    = edge_n;
        end
      end else if (Rs232_rx == 1'b1) begin
        m_armed = 1'b1;
      end
      ovr_set = good && m_valid && !ready;
      m_done  = good;
      m_ferr  = bad;
      if (good && (!m_valid || ready)) begin
        m_data  = word;
        m_valid = 1'b1;
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      if (ovr_set) m_ovr = 1'b1;
      else if (clr_err) m_ovr = 1'b0;
    end
    edge_n++;
  endtask

  task automatic compare();
    n_total++;
    if ({data_out, valid, done, frame_err, overrun} === {m_data, m_valid, m_done, m_ferr, m_ovr}) begin
      n_pass++;
    end else begin
      $display("FAIL model edge %0d: got data=%h v=%b d=%b fe=%b ov=%b, expected data=%h v=%b d=%b fe=%b ov=%b",
               edge_n, data_out, valid, done, frame_err, overrun, m_data, m_valid, m_done, m_ferr, m_ovr);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic cycle(input logic line, input logic rdy, input logic clr);
    Rs232_rx = line;
    ready    = rdy;
    clr_err  = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    if (done) done_cnt++;
    if (frame_err) ferr_cnt++;
  endtask

  function automatic logic pick(input int sel);
    if (sel == 0) return 1'b0;
    else if (sel == 1) return 1'b1;
    else return 1'($urandom_range(0, 1));
  endfunction

  task automatic send_frame(input logic [DW-1:0] w, input logic stp, input int rsel, input int ssel,
                            input logic gx);
    cycle(1'b0, pick(rsel), 1'b0);
    for (int i = 0; i < DW; i++) cycle(w[DW-1-i], pick(rsel), 1'b0);
    for (int g = 0; g < GB; g++) begin
      if (gx) cycle(1'bx, pick(rsel), 1'b0);
      else cycle(1'($urandom_range(0, 1)), pick(rsel), 1'b0);
    end
    pre_valid = valid;
    cycle(stp, pick(ssel), 1'b0);
  endtask

  initial begin
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    check("reset_state", 32'({data_out, valid, done, frame_err, overrun}), 32'd0);
    Rst_rx_n = 1'b1;
    repeat (3) cycle(1'b1, 1'b1, 1'b0);

    send_frame(8'hA5, 1'b1, 1, 1, 1'b1);
    check("a5_valid_before_stop", 32'(pre_valid), 32'd0);
    check("a5_data", 32'(data_out), 32'h0000_00A5);
    check("a5_valid", 32'(valid), 32'd1);
    check("a5_done", 32'(done), 32'd1);
    check("a5_frame_err", 32'(frame_err), 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    check("a5_consumed", 32'(valid), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);

    send_frame(8'h3C, 1'b0, 1, 1, 1'b0);
    check("ferr_pulse", 32'(frame_err), 32'd1);
    check("ferr_no_valid", 32'(valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b0);
    check("ferr_one_cycle", 32'(frame_err), 32'd0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1, 1, 1'b0);
    check("after_ferr_data", 32'(data_out), 32'h0000_0081);
    check("after_ferr_valid", 32'(valid), 32'd1);
    cycle(1'b1, 1'b1, 1'b0);

    done_cnt = 0;
    send_frame(8'h11, 1'b1, 0, 0, 1'b0);
    send_frame(8'h22, 1'b1, 0, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("ovr_data_kept", 32'(data_out), 32'h0000_0011);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_done_twice", 32'(done_cnt), 32'd2);
    cycle(1'b1, 1'b1, 1'b1);
    check("ovr_cleared", 32'(overrun), 32'd0);
    check("ovr_valid_drop", 32'(valid), 32'd0);

    send_frame(8'h11, 1'b1, 0, 0, 1'b0);
    check("simul_first", 32'(data_out), 32'h0000_0011);
    send_frame(8'h22, 1'b1, 0, 1, 1'b0);
    check("simul_data", 32'(data_out), 32'h0000_0022);
    check("simul_valid", 32'(valid), 32'd1);
    check("simul_no_ovr", 32'(overrun), 32'd0);

    cycle(1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    Rst_rx_n = 1'b0;
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    check("midframe_reset", 32'({data_out, valid, done, frame_err, overrun}), 32'd0);
    Rst_rx_n = 1'b1;
    done_cnt = 0;
    ferr_cnt = 0;
    repeat (16) cycle(1'b0, 1'b1, 1'b0);
    check("low_no_start", 32'(done_cnt + ferr_cnt), 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1, 1, 1'b0);
    check("after_reset_data", 32'(data_out), 32'h0000_005A);
    check("after_reset_valid", 32'(valid), 32'd1);

    repeat (300) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) cycle(1'b1, pick(2), 1'($urandom_range(0, 15) == 0));
      send_frame(DW'($urandom), 1'($urandom_range(0, 9) != 0), 2, 2, 1'b0);
    end
    repeat (3) cycle(1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
